// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags, synchronous
// flush and a selectable first-word-fall-through read port.
//
// Occupancy is derived from a pair of (AW+1)-bit pointers. The extra MSB
// tells "full" apart from "empty" when the index bits match. All status
// outputs are decoded from the registered pointers, so they change one
// cycle after the edge that accepted a push or pop.

module param_sync_fifo #(
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    parameter int FWFT   = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DW-1:0]           din,
    output logic [DW-1:0]           dout,
    output logic                    full,
    output logic                    a_full,
    output logic                    empty,
    output logic                    a_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Thresholds cast once to pointer width so every compare is same-width.
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LVL);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    // Storage is deliberately left out of reset; the pointers gate its use.
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [PW-1:0] occ;

    logic pop_ok;
    logic push_ok;
    logic wr_en;
    logic rd_en;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Modulo subtraction gives the occupancy across pointer wrap.
    assign occ = wr_ptr_q - rd_ptr_q;

    // ------------------------------------------------------------------
    // Status decode (purely from registered pointers / flags)
    // ------------------------------------------------------------------
    assign count   = occ;
    assign empty   = (occ == '0);
    assign full    = (occ == DEPTH_C);
    assign a_full  = (occ >= AF_C);
    assign a_empty = (occ <= AE_C);
    assign ovf     = ovf_q;
    assign udf     = udf_q;

    // Accept logic: a pop frees a slot in the same cycle, so push+pop on a
    // full FIFO is accepted. Flush overrides both and suppresses the writes.
    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        wr_en   = push_ok & ~flush;
        rd_en   = pop_ok & ~flush;
    end

    // Next-state for pointers and sticky error flags; flush wins over all.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ONE_C;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE_C;
            if (push & ~push_ok) ovf_d = 1'b1;
            if (pop & empty)     udf_d = 1'b1;
        end
    end

    // Pointer and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; no reset so it maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is shown directly; pop only acknowledges it.
            assign dout = empty ? '0 : mem_q[rd_idx];
        end else begin : g_reg
            logic [DW-1:0] dout_q;

            // Registered read: capture the head on an accepted pop. Because
            // the capture uses the pre-edge array contents, a push+pop on a
            // full FIFO (same index) still returns the old entry.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dout_q <= '0;
                end else if (rd_en) begin
                    dout_q <= mem_q[rd_idx];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: one registered-read instance and one
// FWFT instance. Stimulus pushes expected read data into per-instance
// queues; a monitor pops and compares whenever an accepted read produces
// data. Flag/count checks are made directly by the stimulus.

module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance (u0)
    logic       rstn0, push0, pop0, flush0;
    logic [7:0] din0, dout0;
    logic       full0, a_full0, empty0, a_empty0, ovf0, udf0;
    logic [2:0] count0;

    // FWFT instance (u1)
    logic       rstn1, push1, pop1, flush1;
    logic [7:0] din1, dout1;
    logic       full1, a_full1, empty1, a_empty1, ovf1, udf1;
    logic [2:0] count1;

    param_sync_fifo #(.DW(8), .DEPTH(4), .FWFT(0)) u0 (
        .clk(clk), .rstn(rstn0), .push(push0), .pop(pop0), .flush(flush0),
        .din(din0), .dout(dout0), .full(full0), .a_full(a_full0),
        .empty(empty0), .a_empty(a_empty0), .count(count0),
        .ovf(ovf0), .udf(udf0)
    );

    param_sync_fifo #(.DW(8), .DEPTH(4), .FWFT(1)) u1 (
        .clk(clk), .rstn(rstn1), .push(push1), .pop(pop1), .flush(flush1),
        .din(din1), .dout(dout1), .full(full1), .a_full(a_full1),
        .empty(empty1), .a_empty(a_empty1), .count(count1),
        .ovf(ovf1), .udf(udf1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus on u0; inputs return to idle afterwards.
    task automatic cyc0(input logic pu, input logic po, input logic fl, input logic [7:0] d);
        push0 = pu; pop0 = po; flush0 = fl; din0 = d;
        @(posedge clk); #1;
        push0 = 1'b0; pop0 = 1'b0; flush0 = 1'b0; din0 = 8'h00;
    endtask

    task automatic cyc1(input logic pu, input logic po, input logic fl, input logic [7:0] d);
        push1 = pu; pop1 = po; flush1 = fl; din1 = d;
        @(posedge clk); #1;
        push1 = 1'b0; pop1 = 1'b0; flush1 = 1'b0; din1 = 8'h00;
    endtask

    // Monitor: u0 data appears the cycle after an accepted pop; u1 data is
    // compared while it is presented during an accepted pop.
    initial begin
        logic pend0;
        logic [7:0] e;
        pend0 = 1'b0;
        forever begin
            @(negedge clk);
            if (pend0) begin
                if (q0.size() == 0) chk("u0_unexpected_read", 32'(dout0), 32'hFFFF_FFFF);
                else begin
                    e = q0.pop_front();
                    chk("u0_dout", 32'(dout0), 32'(e));
                end
            end
            pend0 = rstn0 & pop0 & ~empty0 & ~flush0;
            if (rstn1 && pop1 && !empty1 && !flush1) begin
                if (q1.size() == 0) chk("u1_unexpected_read", 32'(dout1), 32'hFFFF_FFFF);
                else begin
                    e = q1.pop_front();
                    chk("u1_dout", 32'(dout1), 32'(e));
                end
            end
        end
    end

    // Wrap-around table: push/pop per cycle and resulting occupancy.
    localparam int WN = 17;
    logic [WN-1:0] wpu = 17'b1_1101_1100_1110_0111; // bit i = step i
    logic [WN-1:0] wpo = 17'b0_1110_1011_1001_1000;
    int            wcnt[WN] = '{1,2,3,2,1,2,3,3,2,1,2,2,3,2,2,2,3};

    initial begin
        logic [7:0] d;
        rstn0 = 1'b0; push0 = 1'b0; pop0 = 1'b0; flush0 = 1'b0; din0 = 8'h00;
        rstn1 = 1'b0; push1 = 1'b0; pop1 = 1'b0; flush1 = 1'b0; din1 = 8'h00;
        #1;
        // Reset state
        chk("rst_empty",   32'(empty0),   1);
        chk("rst_a_empty", 32'(a_empty0), 1);
        chk("rst_full",    32'(full0),    0);
        chk("rst_a_full",  32'(a_full0),  0);
        chk("rst_count",   32'(count0),   0);
        chk("rst_dout",    32'(dout0),    0);
        chk("rst_ovf",     32'(ovf0),     0);
        chk("rst_udf",     32'(udf0),     0);
        chk("rst_dout_f",  32'(dout1),    0);
        @(posedge clk); #1;
        rstn0 = 1'b1; rstn1 = 1'b1;
        @(posedge clk); #1;

        // ---- Basic fill / drain ----
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i);
            q0.push_back(d);
            cyc0(1'b1, 1'b0, 1'b0, d);
            if (i == 0) chk("fill1_a_empty", 32'(a_empty0), 1);
            if (i == 1) chk("fill2_a_empty", 32'(a_empty0), 0);
            if (i == 2) begin
                chk("fill3_a_full", 32'(a_full0), 1);
                chk("fill3_full",   32'(full0),   0);
                chk("fill3_count",  32'(count0),  3);
            end
        end
        chk("fill4_full",  32'(full0),  1);
        chk("fill4_count", 32'(count0), 4);
        for (int i = 0; i < 4; i++) begin
            cyc0(1'b0, 1'b1, 1'b0, 8'h00);
            cyc0(1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("drain_empty",   32'(empty0),   1);
        chk("drain_a_empty", 32'(a_empty0), 1);
        chk("drain_count",   32'(count0),   0);
        chk("drain_ovf",     32'(ovf0),     0);
        chk("drain_udf",     32'(udf0),     0);

        // ---- Overflow ----
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i);
            q0.push_back(d);
            cyc0(1'b1, 1'b0, 1'b0, d);
        end
        cyc0(1'b1, 1'b0, 1'b0, 8'h14);
        chk("ovf_set",   32'(ovf0),   1);
        chk("ovf_count", 32'(count0), 4);
        for (int i = 0; i < 4; i++) cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_sticky", 32'(ovf0),  1);
        chk("ovf_empty",  32'(empty0), 1);
        cyc0(1'b0, 1'b0, 1'b1, 8'h00);
        chk("flush_ovf_clr",   32'(ovf0),  0);
        chk("flush_dout_hold", 32'(dout0), 32'h13);

        // ---- Underflow ----
        cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_set",   32'(udf0),   1);
        chk("udf_dout",  32'(dout0),  32'h13);
        chk("udf_count", 32'(count0), 0);
        q0.push_back(8'h40);
        cyc0(1'b1, 1'b1, 1'b0, 8'h40);
        chk("udf_pp_count", 32'(count0), 1);
        chk("udf_pp_udf",   32'(udf0),   1);
        cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b1, 8'h00);
        chk("flush_udf_clr", 32'(udf0), 0);

        // ---- Full with simultaneous push+pop ----
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i);
            q0.push_back(d);
            cyc0(1'b1, 1'b0, 1'b0, d);
        end
        q0.push_back(8'h20);
        cyc0(1'b1, 1'b1, 1'b0, 8'h20);
        chk("fullpp_count", 32'(count0), 4);
        chk("fullpp_full",  32'(full0),  1);
        chk("fullpp_ovf",   32'(ovf0),   0);
        for (int i = 0; i < 4; i++) cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fullpp_empty", 32'(empty0), 1);

        // ---- Wrap-around with bouncing occupancy ----
        d = 8'h30;
        for (int i = 0; i < WN; i++) begin
            if (wpu[i]) q0.push_back(d);
            cyc0(wpu[i], wpo[i], 1'b0, d);
            if (wpu[i]) d = d + 8'h01;
            chk("wrap_count",   32'(count0),   32'(wcnt[i]));
            chk("wrap_a_full",  32'(a_full0),  32'(wcnt[i] >= 3));
            chk("wrap_a_empty", 32'(a_empty0), 32'(wcnt[i] <= 1));
            chk("wrap_full",    32'(full0),    0);
            chk("wrap_empty",   32'(empty0),   0);
        end
        chk("wrap_npush", 32'(d), 32'h3C);
        for (int i = 0; i < 3; i++) cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap_drained", 32'(empty0), 1);
        chk("wrap_flags",   32'({ovf0, udf0}), 0);

        // ---- FWFT ----
        q1.push_back(8'h55);
        cyc1(1'b1, 1'b0, 1'b0, 8'h55);
        chk("fwft_show",  32'(dout1),  32'h55);
        chk("fwft_nempt", 32'(empty1), 0);
        cyc1(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_pop_dout",  32'(dout1),  0);
        chk("fwft_pop_empty", 32'(empty1), 1);

        // Flush with three entries and ovf set
        for (int i = 0; i < 4; i++) cyc1(1'b1, 1'b0, 1'b0, 8'h61 + 8'(i));
        cyc1(1'b1, 1'b0, 1'b0, 8'h65);
        q1.push_back(8'h61);
        cyc1(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_pre_count", 32'(count1), 3);
        chk("fwft_pre_ovf",   32'(ovf1),   1);
        chk("fwft_pre_dout",  32'(dout1),  32'h62);
        cyc1(1'b1, 1'b1, 1'b1, 8'h66);
        chk("fwft_fl_count", 32'(count1), 0);
        chk("fwft_fl_empty", 32'(empty1), 1);
        chk("fwft_fl_ovf",   32'(ovf1),   0);
        chk("fwft_fl_udf",   32'(udf1),   0);
        chk("fwft_fl_dout",  32'(dout1),  0);

        // Asynchronous reset in the middle of a push burst
        cyc1(1'b1, 1'b0, 1'b0, 8'h70);
        cyc1(1'b1, 1'b0, 1'b0, 8'h71);
        push1 = 1'b1; din1 = 8'h72;
        #2;
        rstn1 = 1'b0;
        #1;
        chk("arst_count",   32'(count1),   0);
        chk("arst_empty",   32'(empty1),   1);
        chk("arst_a_empty", 32'(a_empty1), 1);
        chk("arst_full",    32'({full1, a_full1}), 0);
        chk("arst_dout",    32'(dout1),    0);
        push1 = 1'b0; din1 = 8'h00;
        @(posedge clk); #1;
        rstn1 = 1'b1;
        q1.push_back(8'h80);
        cyc1(1'b1, 1'b0, 1'b0, 8'h80);
        chk("arst_first_count", 32'(count1), 1);
        chk("arst_first_dout",  32'(dout1),  32'h80);
        cyc1(1'b0, 1'b1, 1'b0, 8'h00);
        chk("arst_drain_empty", 32'(empty1), 1);

        @(posedge clk); #1;
        chk("q0_consumed", 32'(q0.size()), 0);
        chk("q1_consumed", 32'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against any unexpected stall of the stimulus.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Single-clock, parametrised synchronous FIFO and the successor to the fixed 8x4 FIFO.
- Adds a generic width and depth, programmable almost-full and almost-empty thresholds, and an occupancy count.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the general buffering element between producer/consumer blocks in the SoC lab designs.

Parameters:
- DW, 8, data width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AF_LVL, DEPTH-1, a_full asserted when count >= AF_LVL (1..DEPTH).
- AE_LVL, 1, a_empty asserted when count <= AE_LVL (0..DEPTH-1).
- FWFT, 0, 0 = registered read (1-cycle latency after pop); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- push  in  1  write request.
- pop  in  1  read request.
- flush  in  1  synchronous clear of contents and error flags.
- din  in  DW  write data.
- dout  out  DW  read data.
- full  out  1  count == DEPTH.
- a_full  out  1  count >= AF_LVL.
- empty  out  1  count == 0.
- a_empty  out  1  count <= AE_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: a push was rejected.
- udf  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rstn low, asynchronous): wr/rd pointers 0, count 0, dout 0, ovf 0, udf 0. Outputs are then empty=1, a_empty=1, full=0, a_full=0. Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits; they wrap naturally. count = wr_ptr - rd_ptr (modulo arithmetic).
- All status flags are decoded combinationally from registered pointers, so they update in the cycle after the accepting edge.
- pop_ok = pop & !empty.
- push_ok = push & (!full | pop_ok). When full, a simultaneous push+pop is legal: both are accepted, count unchanged, and the read returns the old entry (read-before-write).
- Empty with push+pop: push accepted, pop rejected, udf set, count becomes 1.
- push_ok writes din to mem[wr_ptr] and increments wr_ptr. pop_ok increments rd_ptr.
- FWFT=0: on a pop_ok edge, dout registers mem[rd_ptr] (the oldest entry); otherwise dout holds. Data is visible the cycle after the pop edge.
- FWFT=1: dout = mem[rd_ptr] combinationally when !empty, 0 when empty. pop_ok acknowledges the displayed word, and the next word appears after the edge.
- ovf is set on push & !push_ok. udf is set on pop & empty. Both stay set until reset or flush.
- flush (sync, highest priority over push/pop):
  - pointers to 0; ovf and udf to 0;
  - push/pop in that cycle are ignored and do not set error flags;
  - FWFT=0: dout holds its last value.
- Reset asserted mid-burst: outputs take their reset values immediately without waiting for clk. First accepted push after rstn rises lands in entry 0.

Test Plan:
- DW=8, DEPTH=4, FWFT=0:
  - push 0x10,0x11,0x12,0x13 on consecutive cycles -> a_full=1 after the 3rd, full=1 and count=4 after the 4th. Then pop four times at every other cycle -> dout 0x10,0x11,0x12,0x13, each one cycle after its pop. Finally empty=1, a_empty=1, count=0, ovf=udf=0.
  - Overflow: fill with 0x10..0x13, then push 0x14 without pop -> ovf=1, count stays 4. Draining yields 0x10..0x13 only; 0x14 is never output.
  - Underflow: pop while empty -> udf=1, dout unchanged, count 0. Then push+pop together on empty -> count=1, udf stays 1.
  - Full simultaneous: holding 0x10..0x13, push 0x20 with pop -> dout=0x10, count=4, full stays 1. Drain -> 0x11,0x12,0x13,0x20.
- Wrap-around: 12 interleaved push/pop cycles (data 0x30..0x3B, count bouncing 1..3) -> data out in order across pointer wrap, no flag glitch.
- FWFT=1:
  - push 0x55 -> dout=0x55 the cycle after the push with no pop; pop -> dout=0, empty=1.
  - Flush with 3 entries and ovf=1 -> next cycle count=0, empty=1, ovf=0.
  - rstn low mid-push-burst -> outputs at reset values immediately.
